traffic_light_monitor: RTL

Passive checker that sits on the output side of the `traffic_light` controller and consumes its `ns_light`/`ew_light` buses. It decodes each direction's lamp code every clock and tracks per-direction phase state and duration. It flags the first safety or sequencing violation with a sticky fault and a code. It also counts completed north-south cycles, so benches and on-chip self-test can qualify the controller without a reference model.

---
 rtl/traffic_light_pkg.sv | 27 ++
 rtl/light_channel_checker.sv | 73 +++++++
 rtl/traffic_light_monitor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, fault codes and counter width for the traffic light monitor.
package traffic_light_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    FC_NONE          = 3'd0,
    FC_ILLEGAL_CODE  = 3'd1,
    FC_CONFLICT      = 3'd2,
    FC_BAD_SEQ       = 3'd3,
    FC_YELLOW_TIME   = 3'd4,
    FC_GREEN_TIMEOUT = 3'd5
  } fault_code_e;

  function automatic logic lamp_is_legal(input logic [2:0] code);
    return (code == RED) || (code == YELLOW) || (code == GREEN);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/light_channel_checker.sv
// Per-direction lamp tracker: remembers the last legal lamp and its run length,
// and flags illegal codes, bad transitions and phase-duration violations.
module light_channel_checker
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MAX     = 10,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_i,
  output logic       illegal_o,
  output logic       bad_seq_o,
  output logic       yellow_time_o,
  output logic       green_timeout_o,
  output logic       cycle_done_o
);

  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] run_q, run_d;

  // Phase state register; cleared to a red phase of length zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= RED;
      run_q  <= {CNT_W{1'b0}};
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

  // Classify the current sample against the stored phase and compute its successor.
  always_comb begin
    prev_d          = prev_q;
    run_d           = run_q;
    illegal_o       = 1'b0;
    bad_seq_o       = 1'b0;
    yellow_time_o   = 1'b0;
    green_timeout_o = 1'b0;
    cycle_done_o    = 1'b0;
    if (!lamp_is_legal(light_i)) begin
      // Illegal samples leave the tracked phase untouched.
      illegal_o = 1'b1;
    end else if (light_i == prev_q) begin
      run_d = sat_inc(run_q);
      if ((prev_q == YELLOW) && (run_q == CNT_W'(YELLOW_CYCLES))) begin
        yellow_time_o = 1'b1;
      end else if ((prev_q == GREEN) && (run_q == CNT_W'(GREEN_MAX))) begin
        green_timeout_o = 1'b1;
      end else begin
        yellow_time_o = 1'b0;
      end
    end else begin
      prev_d = light_i;
      run_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      case (prev_q)
        RED:     bad_seq_o = (light_i != GREEN);
        GREEN:   bad_seq_o = (light_i != YELLOW);
        YELLOW: begin
          if (light_i == RED) begin
            cycle_done_o  = 1'b1;
            yellow_time_o = (run_q != CNT_W'(YELLOW_CYCLES));
          end else begin
            bad_seq_o = 1'b1;
          end
        end
        default: bad_seq_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic_light controller outputs: latches the first
// safety/sequencing violation and counts completed north-south cycles.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MAX     = 10,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ns_light,
  input  logic [2:0]       ew_light,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_dir,
  output logic [CNT_W-1:0] ns_cycles
);

  logic ns_illegal_s, ns_bad_seq_s, ns_yellow_s, ns_green_s, ns_done_s;
  logic ew_illegal_s, ew_bad_seq_s, ew_yellow_s, ew_green_s, ew_done_s;
  logic conflict_s;

  fault_code_e      code_s;
  logic             dir_s;
  logic             fault_q, fault_d;
  fault_code_e      code_q, code_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] ns_cycles_q, ns_cycles_d;

  light_channel_checker #(
    .GREEN_MAX     (GREEN_MAX),
    .YELLOW_CYCLES (YELLOW_CYCLES)
  ) u_ns (
    .clk             (clk),
    .reset           (reset),
    .light_i         (ns_light),
    .illegal_o       (ns_illegal_s),
    .bad_seq_o       (ns_bad_seq_s),
    .yellow_time_o   (ns_yellow_s),
    .green_timeout_o (ns_green_s),
    .cycle_done_o    (ns_done_s)
  );

  light_channel_checker #(
    .GREEN_MAX     (GREEN_MAX),
    .YELLOW_CYCLES (YELLOW_CYCLES)
  ) u_ew (
    .clk             (clk),
    .reset           (reset),
    .light_i         (ew_light),
    .illegal_o       (ew_illegal_s),
    .bad_seq_o       (ew_bad_seq_s),
    .yellow_time_o   (ew_yellow_s),
    .green_timeout_o (ew_green_s),
    .cycle_done_o    (ew_done_s)
  );

  assign conflict_s = (ns_light != RED) && (ew_light != RED);

  // Lowest code wins; within a code NS wins over EW. CONFLICT always reports NS.
  always_comb begin
    code_s = FC_NONE;
    dir_s  = 1'b0;
    if (ns_illegal_s) begin
      code_s = FC_ILLEGAL_CODE;
    end else if (ew_illegal_s) begin
      code_s = FC_ILLEGAL_CODE;
      dir_s  = 1'b1;
    end else if (conflict_s) begin
      code_s = FC_CONFLICT;
    end else if (ns_bad_seq_s) begin
      code_s = FC_BAD_SEQ;
    end else if (ew_bad_seq_s) begin
      code_s = FC_BAD_SEQ;
      dir_s  = 1'b1;
    end else if (ns_yellow_s) begin
      code_s = FC_YELLOW_TIME;
    end else if (ew_yellow_s) begin
      code_s = FC_YELLOW_TIME;
      dir_s  = 1'b1;
    end else if (ns_green_s) begin
      code_s = FC_GREEN_TIMEOUT;
    end else if (ew_green_s) begin
      code_s = FC_GREEN_TIMEOUT;
      dir_s  = 1'b1;
    end else begin
      code_s = FC_NONE;
    end
  end

  // Sticky first-fault capture and NS cycle counting (which continues after a fault).
  always_comb begin
    fault_d     = fault_q;
    code_d      = code_q;
    dir_d       = dir_q;
    ns_cycles_d = ns_cycles_q + {{(CNT_W-1){1'b0}}, ns_done_s};
    if (!fault_q && (code_s != FC_NONE)) begin
      fault_d = 1'b1;
      code_d  = code_s;
      dir_d   = dir_s;
    end else begin
      fault_d = fault_q;
    end
  end

  // Output registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      dir_q       <= 1'b0;
      ns_cycles_q <= {CNT_W{1'b0}};
    end else begin
      fault_q     <= fault_d;
      code_q      <= code_d;
      dir_q       <= dir_d;
      ns_cycles_q <= ns_cycles_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign ns_cycles  = ns_cycles_q;

endmodule
